// File: rtl/boot_load_ctrl.sv
// boot_load_ctrl
//   Frames a 32-bit valid/ready word stream into preload writes for the
//   mini-MIPS instruction and data memories. The core is held in reset
//   until an END header is accepted.
//
//   Header word: [31:30] cmd (01 IMEM, 10 DMEM, 11 END, 00 illegal),
//                [25:16] base address, [9:0] word count.
//
// Ports
//   clk           system clock, rising edge
//   rst           asynchronous active-low reset
//   start         one-cycle pulse; begins or restarts a load session
//   s_valid       stream word valid
//   s_ready       stream word accepted when s_valid & s_ready
//   s_data        stream word (header or payload)
//   inst_we       one-cycle instruction memory write strobe
//   inst_addr     instruction memory write address (zero-extended)
//   inst_data_in  instruction word to write
//   mem_we        one-cycle data memory write strobe
//   mem_addr      data memory write address (zero-extended)
//   mem_data_in   data word to write
//   cpu_rst       active-high core reset; low only in RUN
//   busy          high in HDR or DATA
//   done          high in RUN
//   err           high in ERR
module boot_load_ctrl #(
  parameter int unsigned IMEM_DEPTH = 32,
  parameter int unsigned DMEM_DEPTH = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [31:0] s_data,
  output logic        inst_we,
  output logic [31:0] inst_addr,
  output logic [31:0] inst_data_in,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_data_in,
  output logic        cpu_rst,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    DATA,
    RUN,
    ERR
  } state_t;

  state_t      state, state_nx;
  logic [10:0] ptr, ptr_nx;
  logic [9:0]  rem, rem_nx;
  logic        tgt_dmem, tgt_dmem_nx;

  logic        inst_we_nx, mem_we_nx;
  logic [31:0] inst_addr_nx, inst_data_nx, mem_addr_nx, mem_data_nx;
  logic        s_ready_nx, busy_nx, done_nx, err_nx, cpu_rst_nx;

  logic        hs;
  logic [1:0]  hdr_cmd;
  logic [9:0]  hdr_base, hdr_count;
  logic [10:0] hdr_sum, hdr_limit;
  logic        unused_hdr_bits;

  assign hs        = s_valid & s_ready;
  assign hdr_cmd   = s_data[31:30];
  assign hdr_base  = s_data[25:16];
  assign hdr_count = s_data[9:0];
  // 11-bit sum so base + count can never wrap before the depth compare
  assign hdr_sum   = {1'b0, hdr_base} + {1'b0, hdr_count};
  assign hdr_limit = (hdr_cmd == 2'b10) ? 11'(DMEM_DEPTH) : 11'(IMEM_DEPTH);
  assign unused_hdr_bits = ^{s_data[29:26], s_data[15:10]};

  always_comb begin
    state_nx     = state;
    ptr_nx       = ptr;
    rem_nx       = rem;
    tgt_dmem_nx  = tgt_dmem;
    inst_we_nx   = 1'b0;
    mem_we_nx    = 1'b0;
    inst_addr_nx = inst_addr;
    inst_data_nx = inst_data_in;
    mem_addr_nx  = mem_addr;
    mem_data_nx  = mem_data_in;

    unique case (state)
      IDLE: begin
        if (start) state_nx = HDR;
      end
      HDR: begin
        if (hs) begin
          unique case (hdr_cmd)
            2'b00: state_nx = ERR;
            2'b11: state_nx = RUN;
            default: begin
              if (hdr_sum > hdr_limit) begin
                state_nx = ERR;
              end else if (hdr_count != 10'd0) begin
                tgt_dmem_nx = (hdr_cmd == 2'b10);
                ptr_nx      = {1'b0, hdr_base};
                rem_nx      = hdr_count;
                state_nx    = DATA;
              end
            end
          endcase
        end
      end
      DATA: begin
        if (hs) begin
          if (tgt_dmem) begin
            mem_we_nx   = 1'b1;
            mem_addr_nx = {21'd0, ptr};
            mem_data_nx = s_data;
          end else begin
            inst_we_nx   = 1'b1;
            inst_addr_nx = {21'd0, ptr};
            inst_data_nx = s_data;
          end
          ptr_nx = ptr + 11'd1;
          rem_nx = rem - 10'd1;
          if (rem == 10'd1) state_nx = HDR;
        end
      end
      RUN, ERR: begin
        if (start) state_nx = HDR;
      end
      default: state_nx = IDLE;
    endcase

    // Status outputs are registered from the next state so they line up
    // with the state they describe.
    s_ready_nx = (state_nx == HDR) || (state_nx == DATA);
    busy_nx    = s_ready_nx;
    done_nx    = (state_nx == RUN);
    err_nx     = (state_nx == ERR);
    cpu_rst_nx = (state_nx != RUN);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      ptr          <= '0;
      rem          <= '0;
      tgt_dmem     <= 1'b0;
      inst_we      <= 1'b0;
      inst_addr    <= '0;
      inst_data_in <= '0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_data_in  <= '0;
      s_ready      <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      cpu_rst      <= 1'b1;
    end else begin
      state        <= state_nx;
      ptr          <= ptr_nx;
      rem          <= rem_nx;
      tgt_dmem     <= tgt_dmem_nx;
      inst_we      <= inst_we_nx;
      inst_addr    <= inst_addr_nx;
      inst_data_in <= inst_data_nx;
      mem_we       <= mem_we_nx;
      mem_addr     <= mem_addr_nx;
      mem_data_in  <= mem_data_nx;
      s_ready      <= s_ready_nx;
      busy         <= busy_nx;
      done         <= done_nx;
      err          <= err_nx;
      cpu_rst      <= cpu_rst_nx;
    end
  end

endmodule

// File: tb/tb_boot_load_ctrl.sv
// Testbench for boot_load_ctrl: directed load sessions checked every cycle
// against a word-level behavioural model, plus literal end-of-step checks
// on captured memory contents and write counts.
module tb_boot_load_ctrl;

  localparam int IMEM_D = 32;
  localparam int DMEM_D = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        s_valid = 1'b0;
  logic [31:0] s_data = 32'hDEAD_BEEF;
  logic        s_ready, inst_we, mem_we, cpu_rst, busy, done, err;
  logic [31:0] inst_addr, inst_data_in, mem_addr, mem_data_in;

  boot_load_ctrl #(.IMEM_DEPTH(IMEM_D), .DMEM_DEPTH(DMEM_D)) dut (
    .clk(clk), .rst(rst), .start(start),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .inst_we(inst_we), .inst_addr(inst_addr), .inst_data_in(inst_data_in),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_data_in(mem_data_in),
    .cpu_rst(cpu_rst), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef enum {M_IDLE, M_HDR, M_DATA, M_RUN, M_ERR} mph_t;
  mph_t        m_phase;
  int          m_ptr, m_left;
  logic        m_dmem;
  logic        e_iwe, e_mwe;
  logic [31:0] e_iaddr, e_idata, e_maddr, e_mdata;

  logic m_take;
  int   h_cmd, h_base, h_cnt, h_depth;
  assign m_take  = s_valid && (m_phase == M_HDR || m_phase == M_DATA);
  assign h_cmd   = int'(s_data[31:30]);
  assign h_base  = int'(s_data[25:16]);
  assign h_cnt   = int'(s_data[9:0]);
  assign h_depth = (h_cmd == 2) ? DMEM_D : IMEM_D;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_phase <= M_IDLE;
      m_ptr   <= 0;
      m_left  <= 0;
      m_dmem  <= 1'b0;
      e_iwe   <= 1'b0;
      e_mwe   <= 1'b0;
      e_iaddr <= '0;
      e_idata <= '0;
      e_maddr <= '0;
      e_mdata <= '0;
    end else begin
      e_iwe <= 1'b0;
      e_mwe <= 1'b0;
      case (m_phase)
        M_IDLE: if (start) m_phase <= M_HDR;
        M_HDR: if (m_take) begin
          if (h_cmd == 0) m_phase <= M_ERR;
          else if (h_cmd == 3) m_phase <= M_RUN;
          else if (h_base + h_cnt > h_depth) m_phase <= M_ERR;
          else if (h_cnt > 0) begin
            m_phase <= M_DATA;
            m_ptr   <= h_base;
            m_left  <= h_cnt;
            m_dmem  <= (h_cmd == 2);
          end
        end
        M_DATA: if (m_take) begin
          if (m_dmem) begin
            e_mwe <= 1'b1; e_maddr <= 32'(m_ptr); e_mdata <= s_data;
          end else begin
            e_iwe <= 1'b1; e_iaddr <= 32'(m_ptr); e_idata <= s_data;
          end
          m_ptr  <= m_ptr + 1;
          m_left <= m_left - 1;
          if (m_left == 1) m_phase <= M_HDR;
        end
        default: if (start) m_phase <= M_HDR;
      endcase
    end
  end

  always @(negedge clk) begin
    chk("s_ready", s_ready, (m_phase == M_HDR || m_phase == M_DATA));
    chk("busy", busy, (m_phase == M_HDR || m_phase == M_DATA));
    chk("done", done, (m_phase == M_RUN));
    chk("err", err, (m_phase == M_ERR));
    chk("cpu_rst", cpu_rst, (m_phase != M_RUN));
    chk("inst_we", inst_we, e_iwe);
    chk("mem_we", mem_we, e_mwe);
    chk("inst_addr", inst_addr, e_iaddr);
    chk("inst_data", inst_data_in, e_idata);
    chk("mem_addr", mem_addr, e_maddr);
    chk("mem_data", mem_data_in, e_mdata);
    chk("we_exclusive", inst_we & mem_we, 1'b0);
  end

  // ---------------- write capture ----------------
  logic [31:0] icap [IMEM_D] = '{default: 32'hFFFF_FFFF};
  logic [31:0] dcap [DMEM_D] = '{default: 32'hFFFF_FFFF};
  int iwc = 0;
  int mwc = 0;

  always @(negedge clk) begin
    if (inst_we) begin
      icap[inst_addr[4:0]] <= inst_data_in;
      iwc <= iwc + 1;
    end
    if (mem_we) begin
      dcap[mem_addr[4:0]] <= mem_data_in;
      mwc <= mwc + 1;
    end
  end

  // ---------------- stimulus ----------------
  function automatic logic [31:0] hdr(input logic [1:0] c, input int b, input int n);
    return {c, 4'b0, 10'(b), 6'b0, 10'(n)};
  endfunction

  task automatic put(input logic [31:0] w);
    @(negedge clk);
    s_valid = 1'b1;
    s_data  = w;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      s_valid = 1'b0;
      s_data  = 32'hDEAD_BEEF;
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  int iw0, mw0;
  logic [31:0] payload [10];

  initial begin
    payload = '{32'd4, 32'd2, 32'd9, 32'd0, 32'd3, 32'd3, 32'd7, 32'd10, 32'd5, 32'd8};
    #2 rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_cpu_rst", cpu_rst, 1'b1);
    chk("rst_s_ready", s_ready, 1'b0);
    rst = 1'b1;
    idle(1);

    // IMEM base 0, 3 words back-to-back, then END
    iw0 = iwc; mw0 = mwc;
    pulse_start();
    put(hdr(2'b01, 0, 3));
    put(32'hAAAA_0001); put(32'hBBBB_0002); put(32'hCCCC_0003);
    put(hdr(2'b11, 0, 0));
    idle(2);
    chk("t1_iwrites", 32'(iwc - iw0), 32'd3);
    chk("t1_imem0", icap[0], 32'hAAAA_0001);
    chk("t1_imem1", icap[1], 32'hBBBB_0002);
    chk("t1_imem2", icap[2], 32'hCCCC_0003);
    chk("t1_cpu_rst", cpu_rst, 1'b0);
    chk("t1_done", done, 1'b1);

    // DMEM base 1, 10 words with gaps
    iw0 = iwc; mw0 = mwc;
    pulse_start();
    put(hdr(2'b10, 1, 10));
    for (int i = 0; i < 10; i++) begin
      put(payload[i]);
      idle(1);
    end
    put(hdr(2'b11, 0, 0));
    idle(2);
    chk("t2_mwrites", 32'(mwc - mw0), 32'd10);
    chk("t2_iwrites", 32'(iwc - iw0), 32'd0);
    for (int i = 0; i < 10; i++) chk("t2_dmem", dcap[i + 1], payload[i]);

    // DMEM base 30 count 3 overflows depth 32
    iw0 = iwc; mw0 = mwc;
    pulse_start();
    put(hdr(2'b10, 30, 3));
    idle(2);
    chk("t3_err", err, 1'b1);
    chk("t3_cpu_rst", cpu_rst, 1'b1);
    chk("t3_writes", 32'(iwc - iw0 + mwc - mw0), 32'd0);
    pulse_start();
    chk("t3_err_clear", err, 1'b0);
    chk("t3_hdr_ready", s_ready, 1'b1);

    // IMEM count 0 then END
    put(hdr(2'b01, 5, 0));
    put(hdr(2'b11, 0, 0));
    idle(2);
    chk("t4_done", done, 1'b1);
    chk("t4_writes", 32'(iwc - iw0 + mwc - mw0), 32'd0);

    // illegal cmd 00
    pulse_start();
    put(hdr(2'b00, 0, 5));
    idle(2);
    chk("t4_illegal_err", err, 1'b1);

    // boundary: base 29 count 3 ends exactly at depth
    pulse_start();
    put(hdr(2'b01, 29, 3));
    put(32'h1111_001D); put(32'h1111_001E); put(32'h1111_001F);
    put(hdr(2'b11, 0, 0));
    idle(2);
    chk("tb_imem29", icap[29], 32'h1111_001D);
    chk("tb_imem31", icap[31], 32'h1111_001F);
    chk("tb_done", done, 1'b1);

    // reload from RUN: one IMEM word then END
    pulse_start();
    chk("t6_cpu_rst_up", cpu_rst, 1'b1);
    chk("t6_done_low", done, 1'b0);
    put(hdr(2'b01, 7, 1));
    put(32'h7777_0007);
    put(hdr(2'b11, 0, 0));
    idle(2);
    chk("t6_imem7", icap[7], 32'h7777_0007);
    chk("t6_cpu_rst_down", cpu_rst, 1'b0);

    // reset mid-payload after 2 of 5 words
    iw0 = iwc;
    pulse_start();
    put(hdr(2'b01, 4, 5));
    put(32'h5555_0004); put(32'h5555_0005); put(32'h5555_0006);
    #1 rst = 1'b0;
    #1;
    chk("t5_rst_iwe", inst_we, 1'b0);
    chk("t5_rst_cpu_rst", cpu_rst, 1'b1);
    chk("t5_rst_ready", s_ready, 1'b0);
    s_valid = 1'b0;
    idle(2);
    rst = 1'b1;
    idle(1);
    chk("t5_partial_writes", 32'(iwc - iw0), 32'd2);
    chk("t5_imem5", icap[5], 32'h5555_0005);
    chk("t5_imem6_untouched", icap[6], 32'hFFFF_FFFF);
    pulse_start();
    put(hdr(2'b01, 4, 2));
    put(32'h6666_0004); put(32'h6666_0005);
    put(hdr(2'b11, 0, 0));
    idle(2);
    chk("t5_reload4", icap[4], 32'h6666_0004);
    chk("t5_reload5", icap[5], 32'h6666_0005);
    chk("t5_done", done, 1'b1);

    idle(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
